// File: rtl/osd_pkg.sv
// Shared constants, control codes and state types for the on-screen-display text console.
package osd_pkg;

  localparam int COLS_DEF = 32;
  localparam int ROWS_DEF = 8;

  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SO    = 8'h0E;
  localparam logic [7:0] SI    = 8'h0F;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCR_RD,
    SCR_WR,
    CLR_ROW,
    CLR_ALL
  } state_t;

  typedef enum logic [2:0] {
    CUR_NOP,
    CUR_ADV,
    CUR_LF,
    CUR_CR,
    CUR_BS,
    CUR_HOME
  } cur_cmd_t;

  // The buffer is 16 bits wide; even character indices live in the low byte.
  function automatic logic [1:0] lane_of(input logic addr_lsb);
    return addr_lsb ? 2'b10 : 2'b01;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/osd_cursor.sv
// Text cursor: advance/wrap/LF/CR/BS/home, linear buffer index and scroll request.
module osd_cursor
  import osd_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  cur_cmd_t   cmd,
  output logic [4:0] cur_x,
  output logic [2:0] cur_y,
  output logic [7:0] index,
  output logic       scroll_req
);

  localparam logic [4:0] X_MAX      = 5'(COLS - 1);
  localparam logic [2:0] Y_MAX      = 3'(ROWS - 1);
  localparam logic [7:0] ROW_STRIDE = 8'(COLS);

  logic at_eol;
  logic at_bottom;

  assign at_eol    = (cur_x == X_MAX);
  assign at_bottom = (cur_y == Y_MAX);
  assign index     = (8'(cur_y) * ROW_STRIDE) + 8'(cur_x);

  // A line feed on the last row, explicit or from wrapping, needs the buffer moved up.
  assign scroll_req = at_bottom && ((cmd == CUR_LF) || ((cmd == CUR_ADV) && at_eol));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      case (cmd)
        CUR_ADV: begin
          if (at_eol) begin
            cur_x <= '0;
            if (!at_bottom) cur_y <= cur_y + 3'd1;
          end else begin
            cur_x <= cur_x + 5'd1;
          end
        end
        CUR_LF: begin
          if (at_bottom) cur_x <= '0;
          else           cur_y <= cur_y + 3'd1;
        end
        CUR_CR: cur_x <= '0;
        CUR_BS: begin
          if (cur_x != 5'd0) cur_x <= cur_x - 5'd1;
        end
        CUR_HOME: begin
          cur_x <= '0;
          cur_y <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/osd_console.sv
// Byte-stream text console writing a COLS x ROWS character buffer, with
// inverse video, clear-screen and read/write scrolling of the whole buffer.
module osd_console
  import osd_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  osd_addr,
  output logic [15:0] osd_data,
  output logic [1:0]  osd_wren,
  output logic        osd_rden,
  input  logic [15:0] osd_q,
  output logic [4:0]  cur_x,
  output logic [2:0]  cur_y,
  output logic        busy
);

  localparam logic [7:0] ROW_STRIDE = 8'(COLS);
  localparam logic [7:0] LAST_MOVE  = 8'(COLS * (ROWS - 1) - 1);
  localparam logic [7:0] LAST_INDEX = 8'(COLS * ROWS - 1);

  state_t      state;
  cur_cmd_t    cur_cmd;
  logic        inv;
  logic        rd_lane;
  logic        accept;
  logic        printable;
  logic        scroll_req;
  logic [7:0]  idx;
  logic [7:0]  cur_index;
  logic [7:0]  rd_byte;
  logic [15:0] data_reg;

  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign accept    = in_valid & in_ready;
  assign printable = is_printable(in_data);

  // Read data only arrives in the write cycle, so the scroll path bypasses data_reg.
  assign rd_byte  = rd_lane ? osd_q[15:8] : osd_q[7:0];
  assign osd_data = (state == SCR_WR) ? {rd_byte, rd_byte} : data_reg;

  always_comb begin
    cur_cmd = CUR_NOP;
    case (state)
      IDLE: begin
        if (accept) begin
          case (in_data)
            LF:      cur_cmd = CUR_LF;
            CR:      cur_cmd = CUR_CR;
            BS:      cur_cmd = CUR_BS;
            default: cur_cmd = CUR_NOP;
          endcase
        end
      end
      PUT:     cur_cmd = CUR_ADV;
      CLR_ALL: if (osd_addr == LAST_INDEX) cur_cmd = CUR_HOME;
      default: cur_cmd = CUR_NOP;
    endcase
  end

  osd_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (cur_cmd),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .index     (cur_index),
    .scroll_req(scroll_req)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      osd_addr <= '0;
      osd_wren <= '0;
      osd_rden <= 1'b0;
      data_reg <= '0;
      inv      <= 1'b0;
      idx      <= '0;
      rd_lane  <= 1'b0;
    end else if (scroll_req) begin
      // Scroll starts with the read of the first character on row 1.
      state    <= SCR_RD;
      idx      <= '0;
      osd_addr <= ROW_STRIDE;
      osd_rden <= 1'b1;
      osd_wren <= '0;
    end else begin
      case (state)
        IDLE: begin
          osd_wren <= '0;
          osd_rden <= 1'b0;
          if (accept) begin
            if (printable) begin
              state    <= PUT;
              osd_addr <= cur_index;
              data_reg <= {2{inv, in_data[6:0]}};
              osd_wren <= lane_of(cur_index[0]);
            end else if (in_data == SO) begin
              inv <= 1'b1;
            end else if (in_data == SI) begin
              inv <= 1'b0;
            end else if (in_data == FF) begin
              state    <= CLR_ALL;
              osd_addr <= '0;
              data_reg <= {SPACE, SPACE};
              osd_wren <= lane_of(1'b0);
            end
          end
        end
        PUT: begin
          state    <= IDLE;
          osd_wren <= '0;
        end
        SCR_RD: begin
          state    <= SCR_WR;
          osd_rden <= 1'b0;
          rd_lane  <= osd_addr[0];
          osd_addr <= idx;
          osd_wren <= lane_of(idx[0]);
        end
        SCR_WR: begin
          if (idx == LAST_MOVE) begin
            state    <= CLR_ROW;
            osd_addr <= idx + 8'd1;
            osd_wren <= lane_of(~idx[0]);
            data_reg <= {SPACE, SPACE};
          end else begin
            state    <= SCR_RD;
            idx      <= idx + 8'd1;
            osd_addr <= idx + ROW_STRIDE + 8'd1;
            osd_rden <= 1'b1;
            osd_wren <= '0;
          end
        end
        CLR_ROW, CLR_ALL: begin
          if (osd_addr == LAST_INDEX) begin
            state    <= IDLE;
            osd_wren <= '0;
          end else begin
            osd_addr <= osd_addr + 8'd1;
            osd_wren <= lane_of(~osd_addr[0]);
          end
        end
        default: begin
          state    <= IDLE;
          osd_wren <= '0;
          osd_rden <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_console.sv
// Randomized scoreboard bench for osd_console with a byte-lane text buffer model.
module tb_osd_console;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  osd_addr;
  logic [15:0] osd_data;
  logic [1:0]  osd_wren;
  logic        osd_rden;
  logic [15:0] osd_q = 16'h0000;
  logic [4:0]  cur_x;
  logic [2:0]  cur_y;
  logic        busy;

  always #5 clk = ~clk;

  osd_console #(.COLS(32), .ROWS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .osd_addr(osd_addr),
    .osd_data(osd_data),
    .osd_wren(osd_wren),
    .osd_rden(osd_rden),
    .osd_q   (osd_q),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .busy    (busy)
  );

  // Text buffer: 128 x 16-bit words, character i in word i/2, byte i%2.
  logic [7:0] ram [256];
  logic       preload_go = 1'b0;

  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i % 128);
    end else begin
      if (osd_wren[0]) ram[{osd_addr[7:1], 1'b0}] <= osd_data[7:0];
      if (osd_wren[1]) ram[{osd_addr[7:1], 1'b1}] <= osd_data[15:8];
    end
    if (osd_rden) osd_q <= {ram[{osd_addr[7:1], 1'b1}], ram[{osd_addr[7:1], 1'b0}]};
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  wren;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mbuf [256];
  int         mx, my;
  bit         minv;
  int         n_checks = 0;
  int         n_fail = 0;
  int         last_wait;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void push_wr(input int a, input logic [7:0] ch);
    wr_t w;
    w.addr = 8'(a);
    w.data = {ch, ch};
    w.wren = (a % 2 == 1) ? 2'b10 : 2'b01;
    exp_q.push_back(w);
    mbuf[a] = ch;
  endfunction

  // Move rows 1..7 up one row and blank the bottom row.
  function automatic void model_scroll();
    for (int i = 0; i < 224; i++) push_wr(i, mbuf[i + 32]);
    for (int i = 224; i < 256; i++) push_wr(i, 8'h20);
  endfunction

  function automatic int model_byte(input logic [7:0] b);
    int stall;
    stall = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(my * 32 + mx, {minv, b[6:0]});
      stall = 1;
      if (mx == 31) begin
        mx = 0;
        if (my < 7) my++;
        else begin model_scroll(); stall += 480; end
      end else mx++;
    end else if (b == 8'h0A) begin
      if (my < 7) my++;
      else begin mx = 0; model_scroll(); stall = 480; end
    end else if (b == 8'h0D) mx = 0;
    else if (b == 8'h08) begin if (mx > 0) mx--; end
    else if (b == 8'h0E) minv = 1'b1;
    else if (b == 8'h0F) minv = 1'b0;
    else if (b == 8'h0C) begin
      for (int i = 0; i < 256; i++) push_wr(i, 8'h20);
      mx = 0; my = 0; stall = 256;
    end
    return stall;
  endfunction

  task automatic monitor_cycle();
    wr_t e;
    if (reset_n) begin
      chk(!(osd_wren != 2'b00 && osd_rden), "rd_wr_overlap", {osd_wren, osd_rden}, 3'b000);
      if (in_ready) chk(osd_wren == 2'b00 && !osd_rden, "idle_access", {osd_wren, osd_rden}, 3'b000);
      if (osd_wren != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", {osd_addr, osd_data, osd_wren}, 0);
        end else begin
          e = exp_q.pop_front();
          chk({osd_addr, osd_data, osd_wren} === e, "write_addr_data_wren",
              {osd_addr, osd_data, osd_wren}, e);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int exp_stall, n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 3000) begin @(posedge clk); #1; n++; end
    last_wait = n;
    if (n >= 3000) chk(in_ready, "accept_timeout", 0, 1);
    exp_stall = model_byte(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 3000) begin @(posedge clk); #1; n++; end
    chk(n == exp_stall, "busy_cycles", n, exp_stall);
    chk(cur_x == 5'(mx) && cur_y == 3'(my), "cursor", {cur_y, cur_x}, {3'(my), 5'(mx)});
  endtask

  task automatic check_buffer(input string name);
    for (int i = 0; i < 256; i++) chk(ram[i] === mbuf[i], name, {i[7:0], ram[i]}, {i[7:0], mbuf[i]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    mx = 0; my = 0; minv = 1'b0;
    for (int i = 0; i < 256; i++) mbuf[i] = 8'(i % 128);
    fork
      forever begin @(negedge clk); monitor_cycle(); end
    join_none

    // Reset and initial buffer image
    preload_go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload_go = 1'b0;
    chk(osd_wren == 2'b00 && !osd_rden, "reset_access", {osd_wren, osd_rden}, 0);
    chk(cur_x == 5'd0 && cur_y == 3'd0, "reset_cursor", {cur_y, cur_x}, 0);
    chk(in_ready && !busy, "reset_ready", {in_ready, busy}, 2'b10);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single character
    send(8'h41);
    chk(ram[0] == 8'h41, "char_A", ram[0], 8'h41);
    chk(cur_x == 5'd1 && cur_y == 3'd0, "cursor_after_A", {cur_y, cur_x}, 8'h01);

    // Inverse video toggling, even then odd lane
    send(8'h0D); send(8'h0E); send(8'h42); send(8'h0F); send(8'h43);
    chk(ram[0] == 8'hC2, "inverse_B", ram[0], 8'hC2);
    chk(ram[1] == 8'h43, "normal_C", ram[1], 8'h43);

    // LF on the bottom row scrolls a known pattern
    send(8'h0D);
    repeat (7) send(8'h0A);
    repeat (5) send(8'h2E);
    preload_go = 1'b1;
    @(posedge clk); #1;
    preload_go = 1'b0;
    for (int i = 0; i < 256; i++) mbuf[i] = 8'(i % 128);
    send(8'h0A);
    chk(ram[0] == 8'd32, "scroll_idx0", ram[0], 8'd32);
    chk(ram[223] == 8'h7F, "scroll_idx223", ram[223], 8'h7F);
    for (int i = 224; i < 256; i++) chk(ram[i] == 8'h20, "scroll_blank_row", {i[7:0], ram[i]}, {i[7:0], 8'h20});
    chk(cur_x == 5'd0 && cur_y == 3'd7, "cursor_after_scroll", {cur_y, cur_x}, {3'd7, 5'd0});

    // Printable in the last cell writes first, then scrolls
    for (int k = 0; k < 31; k++) send(8'(8'h61 + k % 26));
    send(8'h5A);
    chk(ram[223] == 8'h5A, "wrap_scroll_Z", ram[223], 8'h5A);
    chk(cur_x == 5'd0 && cur_y == 3'd7, "cursor_after_wrap", {cur_y, cur_x}, {3'd7, 5'd0});
    check_buffer("buffer_after_wrap");

    // Back-to-back no-stall bytes with in_valid held
    send(8'h0D);
    send(8'h08);
    chk(last_wait == 0, "bs_consecutive", last_wait, 0);
    send(8'h7F);
    chk(last_wait == 0, "del_consecutive", last_wait, 0);
    chk(cur_x == 5'd0, "cursor_x_after_ignored", cur_x, 0);

    // Reset during clear-screen
    in_data = 8'h0C; in_valid = 1'b1;
    void'(model_byte(8'h0C));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    mx = 0; my = 0; minv = 1'b0;
    for (int i = 0; i < 256; i++) mbuf[i] = ram[i];
    chk(osd_wren == 2'b00 && !osd_rden, "abort_access", {osd_wren, osd_rden}, 0);
    chk(cur_x == 5'd0 && cur_y == 3'd0, "abort_cursor", {cur_y, cur_x}, 0);
    chk(in_ready && !busy, "abort_ready", {in_ready, busy}, 2'b10);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Randomized traffic against the reference model
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = 8'($urandom_range(32, 126));
      else if (r < 66) b = 8'h0A;
      else if (r < 72) b = 8'h0D;
      else if (r < 78) b = 8'h08;
      else if (r < 83) b = 8'h0E;
      else if (r < 88) b = 8'h0F;
      else if (r < 90) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      send(b);
    end
    repeat (3) @(posedge clk);
    #1;
    check_buffer("buffer_final");
    chk(exp_q.size() == 0, "pending_writes", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
